seg_msg_sched: RTL and testbench

SEG_MSG_SCHED -- requirements
Module: seg_msg_sched

---
 rtl/seg_msg_sched_if.sv | 25 ++
 rtl/seg_msg_sched.sv | 107 ++++++++++
 tb/tb_seg_msg_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seg_msg_sched_if.sv
// seg_msg_sched_if: status/message inputs and registered display outputs of the message scheduler
interface seg_msg_sched_if;
    logic [31:0] base_value;
    logic [7:0]  base_en;
    logic [1:0]  req;
    logic [63:0] msg_value;
    logic [15:0] msg_en;
    logic [1:0]  msg_blink;
    logic        clr;
    logic [1:0]  ack;
    logic [31:0] seg_value;
    logic [7:0]  seg_en;
    logic        busy;
    logic        active_id;

    modport master (
        output base_value, base_en, req, msg_value, msg_en, msg_blink, clr,
        input  ack, seg_value, seg_en, busy, active_id
    );

    modport slave (
        input  base_value, base_en, req, msg_value, msg_en, msg_blink, clr,
        output ack, seg_value, seg_en, busy, active_id
    );
endinterface

// File: rtl/seg_msg_sched.sv
// seg_msg_sched: shows status digits, temporarily replaced by prioritised timed (optionally blinking) messages
module seg_msg_sched #(
    parameter int HOLD_CYC   = 50_000_000,
    parameter int BLINK_HALF = 12_500_000
) (
    input logic             clk,
    input logic             rst_n,
    seg_msg_sched_if.slave  bus
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [31:0]   lat_val_q, lat_val_d;
    logic [7:0]    lat_en_q, lat_en_d;
    logic          lat_blink_q, lat_blink_d;
    logic [31:0]   seg_value_q, seg_value_d;
    logic [7:0]    seg_en_q, seg_en_d;
    logic [1:0]    ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          id_q, id_d;
    logic          k;

    // state, latched message, counters and all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            blink_q     <= '0;
            phase_q     <= 1'b0;
            lat_val_q   <= '0;
            lat_en_q    <= '0;
            lat_blink_q <= 1'b0;
            seg_value_q <= '0;
            seg_en_q    <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            id_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            lat_val_q   <= lat_val_d;
            lat_en_q    <= lat_en_d;
            lat_blink_q <= lat_blink_d;
            seg_value_q <= seg_value_d;
            seg_en_q    <= seg_en_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            id_q        <= id_d;
        end
    end

    // next state: grant in IDLE (message visible with its ack), hold/blink timing in SHOW
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        blink_d     = blink_q;
        phase_d     = phase_q;
        lat_val_d   = lat_val_q;
        lat_en_d    = lat_en_q;
        lat_blink_d = lat_blink_q;
        seg_value_d = bus.base_value;
        seg_en_d    = bus.base_en;
        ack_d       = 2'b00;
        busy_d      = 1'b0;
        id_d        = id_q;
        k           = bus.req[1];
        if (state_q == IDLE) begin
            if (bus.req != 2'b00 && !bus.clr) begin
                state_d     = SHOW;
                hold_d      = '0;
                blink_d     = '0;
                phase_d     = 1'b0;
                lat_val_d   = k ? bus.msg_value[63:32] : bus.msg_value[31:0];
                lat_en_d    = k ? bus.msg_en[15:8] : bus.msg_en[7:0];
                lat_blink_d = bus.msg_blink[k];
                id_d        = k;
                ack_d[k]    = 1'b1;
                busy_d      = 1'b1;
                seg_value_d = lat_val_d;
                seg_en_d    = lat_en_d;
            end
        end else if (bus.clr || hold_q == HW'(HOLD_CYC - 1)) begin
            state_d = IDLE;
        end else begin
            hold_d      = hold_q + HW'(1);
            blink_d     = (blink_q == BW'(BLINK_HALF - 1)) ? '0 : blink_q + BW'(1);
            phase_d     = (blink_q == BW'(BLINK_HALF - 1)) ? ~phase_q : phase_q;
            busy_d      = 1'b1;
            seg_value_d = lat_val_q;
            seg_en_d    = (lat_blink_q && phase_d) ? 8'h00 : lat_en_q;
        end
    end

    assign bus.seg_value = seg_value_q;
    assign bus.seg_en    = seg_en_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.active_id = id_q;
endmodule

// File: tb/tb_seg_msg_sched.sv
// tb_seg_msg_sched: scoreboard bench comparing the scheduler against a cycle-count reference model
module tb_seg_msg_sched;
    localparam int HOLD_CYC   = 4;
    localparam int BLINK_HALF = 2;

    typedef struct packed {
        logic [31:0] v;
        logic [7:0]  e;
        logic [1:0]  a;
        logic        b;
        logic        id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    seg_msg_sched_if bus();

    seg_msg_sched #(.HOLD_CYC(HOLD_CYC), .BLINK_HALF(BLINK_HALF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  pend = 2'b00;
    logic        m_busy = 1'b0;
    logic        m_id = 1'b0;
    int          m_el = 0;
    logic [31:0] m_v = '0;
    logic [7:0]  m_e = '0;
    logic        m_bl = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference: message phase derived from cycles elapsed since grant
    task automatic model(output exp_t x);
        logic k;
        logic ph;
        x = '{v: bus.base_value, e: bus.base_en, a: 2'b00, b: 1'b0, id: m_id};
        if (!m_busy) begin
            if (bus.req != 2'b00 && !bus.clr) begin
                k      = bus.req[1];
                m_busy = 1'b1;
                m_el   = 0;
                m_id   = k;
                m_v    = k ? bus.msg_value[63:32] : bus.msg_value[31:0];
                m_e    = k ? bus.msg_en[15:8] : bus.msg_en[7:0];
                m_bl   = bus.msg_blink[k];
                x = '{v: m_v, e: m_e, a: (k ? 2'b10 : 2'b01), b: 1'b1, id: k};
            end
        end else if (bus.clr || m_el == HOLD_CYC - 1) begin
            m_busy = 1'b0;
        end else begin
            m_el++;
            ph = ((m_el / BLINK_HALF) % 2) == 1;
            x = '{v: m_v, e: ((m_bl && ph) ? 8'h00 : m_e), a: 2'b00, b: 1'b1, id: m_id};
        end
    endtask

    task automatic step(input logic c);
        exp_t x;
        @(negedge clk);
        bus.req = pend;
        bus.clr = c;
        model(x);
        q.push_back(x);
        pend = pend & ~x.a;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 64'd1, 64'd0);
        end else begin
            x = q.pop_front();
            chk("seg_value", 64'(bus.seg_value), 64'(x.v));
            chk("seg_en", 64'(bus.seg_en), 64'(x.e));
            chk("ack", 64'(bus.ack), 64'(x.a));
            chk("busy", 64'(bus.busy), 64'(x.b));
            if (x.b) chk("active_id", 64'(bus.active_id), 64'(x.id));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_seg_value"}, 64'(bus.seg_value), 64'd0);
        chk({tag, "_seg_en"}, 64'(bus.seg_en), 64'd0);
        chk({tag, "_ack"}, 64'(bus.ack), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_active_id"}, 64'(bus.active_id), 64'd0);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_id   = 1'b0;
        m_el   = 0;
        pend   = 2'b00;
        q.delete();
    endtask

    initial begin
        bus.base_value = 32'h0;
        bus.base_en    = 8'h00;
        bus.req        = 2'b00;
        bus.msg_value  = 64'h0;
        bus.msg_en     = 16'h0;
        bus.msg_blink  = 2'b00;
        bus.clr        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.base_value = 32'hDEAD_BEEF;
        bus.base_en    = 8'hFF;
        bus.req        = 2'b11;
        @(posedge clk);
        #1;
        chk_zero("reset");
        bus.req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        bus.base_value = 32'hAAA0_0000;
        bus.base_en    = 8'hE0;
        repeat (3) step(1'b0);

        bus.msg_value = 64'h1234_5678_3000_0000;
        bus.msg_en    = 16'h3C80;
        pend = 2'b01;
        repeat (7) step(1'b0);

        pend = 2'b11;
        repeat (12) step(1'b0);

        bus.msg_blink = 2'b10;
        bus.msg_en    = 16'hFF80;
        pend = 2'b10;
        repeat (6) step(1'b0);
        bus.msg_blink = 2'b00;

        pend = 2'b01;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);

        pend = 2'b01;
        step(1'b1);
        step(1'b0);
        repeat (5) step(1'b0);

        pend = 2'b01;
        step(1'b0);
        pend = 2'b11;
        step(1'b0);
        pend = 2'b01;
        repeat (5) step(1'b0);

        for (int i = 0; i < 120; i++) begin
            bus.base_value = $urandom;
            bus.base_en    = 8'($urandom);
            bus.msg_value  = {$urandom, $urandom};
            bus.msg_en     = 16'($urandom);
            bus.msg_blink  = 2'($urandom);
            pend = pend | 2'($urandom_range(0, 3) & {2{$urandom_range(0, 3) == 0}});
            if ($urandom_range(0, 9) == 0) pend = 2'b00;
            step($urandom_range(0, 11) == 0);
        end

        bus.base_value = 32'h0F0F_0F0F;
        bus.base_en    = 8'h0F;
        bus.msg_value  = 64'h5555_5555_6666_6666;
        bus.msg_en     = 16'hFFFF;
        bus.clr        = 1'b0;
        pend = 2'b00;
        repeat (HOLD_CYC + 2) step(1'b0);
        pend = 2'b01;
        step(1'b0);
        step(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        bus.req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
